// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one byte-level SPI shift engine between NUM_REQ
// requesters. Requests are arbitrated, a per-slave active-low chip select is
// driven, payload bytes are launched one at a time into the engine, and a
// CS_GAP-cycle all-deselected gap separates consecutive transactions.
// Build option: define SPI_FIXED_PRIO_EN for fixed lowest-index-wins
// arbitration (the round-robin pointer then reads as constant 0).
module spi_txn_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BYTES = 4,
  parameter int CS_GAP    = 8
) (
  input  logic                           CLK12M,
  input  logic                           RST_N,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  output logic [NUM_REQ-1:0]             REQ_READY,
  input  logic [NUM_REQ*3-1:0]           REQ_LEN,
  input  logic [NUM_REQ*8*MAX_BYTES-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]             GRANT,
  output logic [NUM_REQ-1:0]             CSB,
  output logic                           ENG_START,
  output logic [7:0]                     ENG_BYTE,
  output logic                           ENG_LAST,
  input  logic                           ENG_BUSY,
  input  logic                           ENG_DONE
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [2:0]       MAX_LEN   = 3'(MAX_BYTES);
  localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_SETUP, S_SEND, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              win_q, win_d;
  logic [IDX_W-1:0]              idx_q, idx_d, idx_nxt;
  logic [GAP_W-1:0]              gap_q, gap_d;
  logic [NUM_REQ-1:0]            ready_q, ready_d;
  logic [NUM_REQ-1:0]            grant_q, grant_d;
  logic [NUM_REQ-1:0]            csb_q, csb_d;
  logic [7:0]                    eng_byte_q, eng_byte_d;
  logic                          eng_last_q, eng_last_d;
  logic [2:0]                    len_q, len_d;
  logic [MAX_BYTES-1:0][7:0]     data_q, data_d;
  logic                          eng_start;
  logic                          ptr_adv;
  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              win_scan;
  logic                          found;
  logic [PTR_W:0]                cand;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Find the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    win_scan = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && REQ_VALID[cand[PTR_W-1:0]]) begin
        found    = 1'b1;
        win_scan = cand[PTR_W-1:0];
      end
    end
  end

  // Transaction sequencer: next state, chip select, grant and engine byte.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    ready_d    = '0;
    grant_d    = grant_q;
    csb_d      = csb_q;
    eng_byte_d = eng_byte_q;
    eng_last_d = eng_last_q;
    len_d      = len_q;
    data_d     = data_q;
    eng_start  = 1'b0;
    ptr_adv    = 1'b0;
    idx_nxt    = idx_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d           = S_ACCEPT;
          win_d             = win_scan;
          idx_d             = '0;
          ready_d[win_scan] = 1'b1;
          grant_d           = '0;
          grant_d[win_scan] = 1'b1;
          len_d             = REQ_LEN[win_scan*3 +: 3];
          data_d            = REQ_DATA[win_scan*8*MAX_BYTES +: 8*MAX_BYTES];
        end
      end
      S_ACCEPT: begin
        if (len_q == 3'd0 || len_q > MAX_LEN) begin
          // Malformed length: consumed without touching the bus.
          state_d = S_IDLE;
          grant_d = '0;
          ptr_adv = 1'b1;
        end else begin
          state_d        = S_SETUP;
          csb_d          = '1;
          csb_d[win_q]   = 1'b0;
          eng_byte_d     = data_q[0];
          eng_last_d     = (len_q == 3'd1);
        end
      end
      S_SETUP: state_d = S_SEND;
      S_SEND: begin
        if (!ENG_BUSY) begin
          eng_start = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ENG_DONE) begin
          if (eng_last_q) begin
            state_d = S_HOLD;
          end else begin
            state_d    = S_SEND;
            idx_d      = idx_nxt;
            eng_byte_d = data_q[idx_nxt];
            eng_last_d = (3'(idx_nxt) + 3'd1 == len_q);
          end
        end
      end
      S_HOLD: begin
        state_d = S_GAP;
        csb_d   = '1;
        gap_d   = GAP_INIT;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_adv = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset deselects every slave immediately.
  always_ff @(posedge CLK12M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      ready_q    <= '0;
      grant_q    <= '0;
      csb_q      <= '1;
      eng_byte_q <= '0;
      eng_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      ready_q    <= ready_d;
      grant_q    <= grant_d;
      csb_q      <= csb_d;
      eng_byte_q <= eng_byte_d;
      eng_last_q <= eng_last_d;
    end
  end

  // Captured request payload; only meaningful while a transaction is owned.
  always_ff @(posedge CLK12M) begin
    len_q  <= len_d;
    data_q <= data_d;
  end

`ifdef SPI_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Round-robin pointer moves past the owner when its transaction retires.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_adv) ptr_d = wrap_inc(win_q);
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK12M or negedge RST_N) begin
    if (!RST_N) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  assign REQ_READY = ready_q;
  assign GRANT     = grant_q;
  assign CSB       = csb_q;
  assign ENG_START = eng_start;
  assign ENG_BYTE  = eng_byte_q;
  assign ENG_LAST  = eng_last_q;

endmodule
